fwd_hazard_scoreboard: RTL and testbench
========================================

// Module: fwd_hazard_scoreboard
// PURPOSE
//  Parametrised forwarding + load-use hazard unit for the pipelined core. It replaces the fixed 2-source, MEM/WB-only
//  forwarding compare. Holds its own shadow pipeline of in-flight writers: {valid, rd, is_load} for DEPTH stages past EX.
//  Per cycle it produces a forwarding select for every EX source operand and a load-use stall request for ID.
//  It also keeps a saturating count of stall cycles.
// PARAMETERS
//  NUM_SRC    2   source operands per instruction
//  RA_W       5   register address width; register 0 is hardwired zero
//  DEPTH      2   forwardable stages after EX (slot0=MEM, slot1=WB, ...); DEPTH>=1
//  LOAD_READY 1   lowest slot index at which load data is forwardable; 0<=LOAD_READY<=DEPTH-1
//  CNT_W      32  stall counter width
//  SEL_W      derived (localparam) = $clog2(DEPTH+1)
// PORTS
//  clk         in   1              core clock, rising edge
//  rst         in   1              asynchronous, active-high reset
//  freeze      in   1              global pipeline hold (e.g. memory wait)
//  ex_valid    in   1              instruction in EX is real (0 = bubble)
//  ex_regwrite in   1              EX instruction writes rd
//  ex_is_load  in   1              EX instruction is a load
//  ex_rd       in   RA_W           EX destination register
//  ex_rs       in   NUM_SRC*RA_W   EX source registers, src j at [j*RA_W +: RA_W]
//  id_valid    in   1              instruction in ID is real
//  id_rs       in   NUM_SRC*RA_W   ID source registers
//  id_rs_used  in   NUM_SRC        ID source j is actually read
//  fwd_sel     out  NUM_SRC*SEL_W  per EX src: 0=regfile, k=data of slot k-1
//  ld_stall    out  1              hold ID/IF and insert bubble into EX
//  stall_cnt   out  CNT_W          saturating count of stall cycles
// BEHAVIOUR
//  Reset (async, rst=1):
//   - All slot valids clear and stall_cnt=0.
//   - While rst=1, fwd_sel=0 and ld_stall=0, even if reset is asserted mid-operation.
//  Shadow pipeline, on posedge clk when !freeze:
//   - slot0 <= {ex_valid&ex_regwrite&(ex_rd!=0), ex_rd, ex_is_load}.
//   - slot[i] <= slot[i-1] for i=1..DEPTH-1.
//   - The oldest entry is dropped.
//   - When freeze=1, all slots and stall_cnt hold their values.
//  A slot "writes r" when valid=1 and rd==r. r==0 never matches; the reference design lacked this x0 check.
//  fwd_sel (combinational from slots + ex_rs, no latency):
//   - For src j, k = 1 + lowest slot index writing ex_rs[j]. Youngest writer wins.
//   - 0 if no slot writes ex_rs[j].
//   - Computed regardless of ex_valid.
//  ld_stall (combinational):
//   - Set when id_valid=1 and some src j has id_rs_used[j]=1, id_rs[j]!=0, and the YOUNGEST writer of id_rs[j]
//     among {EX, slot0..slotDEPTH-2} is a load that is not yet ready.
//   - EX counts as the youngest position; it is a writer only when ex_valid & ex_regwrite.
//   - "Not yet ready": for the EX position, stall if LOAD_READY>0; for slot i, stall if i+1<LOAD_READY.
//   - A younger non-load writer of the same register shadows an older load: no stall.
//   - ld_stall is independent of freeze. The CPU inserts the bubble (ex_valid=0 next cycle); this block does not.
//  stall_cnt:
//   - +1 on each posedge where ld_stall=1 and !freeze.
//   - Saturates at all-ones and does not wrap.
//  Simultaneous events:
//   - freeze and ld_stall together: no shift, no count.
//   - rst dominates everything.
// TESTING (DEPTH=2, LOAD_READY=1 unless stated)
//  1. Reset mid-stream: rst pulsed while slot0 holds rd=5 -> fwd_sel=0, ld_stall=0, stall_cnt=0.
//     After release, ex_rs0=5 -> fwd_sel[0]=0.
//  2. add x5 in EX at cycle n; ex_rs0=5 at n+1 -> sel=1; at n+2 -> sel=2; at n+3 -> sel=0.
//  3. Back-to-back writes of x5: slot0 and slot1 both rd=5, ex_rs0=ex_rs1=5 -> both sels=1.
//     x0 writer (rd=0, regwrite=1) -> sel=0.
//  4. lw x7 in EX, id_rs0=7 used -> ld_stall=1, stall_cnt 0->1.
//     Same with id_rs_used=0 -> ld_stall=0.
//     Next cycle (bubble in EX, lw in slot0) -> ld_stall=0; the following cycle ex_rs0=7 -> sel=2.
//  5. Shadowing: lw x7 in slot0, add x7 in EX, id_rs0=7 -> ld_stall=0.
//     With LOAD_READY=2 and lw in slot0 only -> ld_stall=1.
//  6. Freeze 3 cycles with slot0 rd=5 -> fwd_sel constant, stall_cnt constant.
//     Force stall_cnt to CNT_W'hFFFF_FFFE, stall 3 cycles -> reads FFFF_FFFF and holds.

Source files
------------

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding select and load-use hazard unit.
// Keeps a shadow pipeline of in-flight register writers for the stages past EX.
// From it, the unit picks a bypass source for every EX operand and requests
// an ID stall when a needed load result is not yet forwardable.
module fwd_hazard_scoreboard #(
    parameter  int NUM_SRC    = 2,
    parameter  int RA_W       = 5,
    parameter  int DEPTH      = 2,
    parameter  int LOAD_READY = 1,
    parameter  int CNT_W      = 32,
    localparam int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      freeze,
    input  logic                      ex_valid,
    input  logic                      ex_regwrite,
    input  logic                      ex_is_load,
    input  logic [RA_W-1:0]           ex_rd,
    input  logic [NUM_SRC*RA_W-1:0]   ex_rs,
    input  logic                      id_valid,
    input  logic [NUM_SRC*RA_W-1:0]   id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic                      ld_stall,
    output logic [CNT_W-1:0]          stall_cnt
);

    // A load sitting in EX can never be forwarded in time unless it is ready at slot 0 or earlier
    localparam logic EX_LOAD_NOT_READY = (LOAD_READY > 0);

    logic [DEPTH-1:0]           slot_valid;
    logic [DEPTH-1:0]           slot_load;
    logic [DEPTH-1:0][RA_W-1:0] slot_rd;
    logic [NUM_SRC*SEL_W-1:0]   sel_comb;
    logic [NUM_SRC-1:0]         src_hazard;
    logic                       stall_comb;
    logic [CNT_W-1:0]           cnt_q;

    // Shift the EX writer into slot 0 and age the older writers; x0 writes never become valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_valid <= '0;
            slot_load  <= '0;
            slot_rd    <= '0;
        end else if (!freeze) begin
            slot_valid[0] <= ex_valid & ex_regwrite & (ex_rd != '0);
            slot_rd[0]    <= ex_rd;
            slot_load[0]  <= ex_is_load;
            for (int i = 1; i < DEPTH; i++) begin
                slot_valid[i] <= slot_valid[i-1];
                slot_rd[i]    <= slot_rd[i-1];
                slot_load[i]  <= slot_load[i-1];
            end
        end
    end

    // Scan oldest to youngest so the youngest matching writer leaves the final select
    always_comb begin
        sel_comb = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (slot_valid[i] && (slot_rd[i] == ex_rs[j*RA_W +: RA_W]) &&
                    (ex_rs[j*RA_W +: RA_W] != '0)) begin
                    sel_comb[j*SEL_W +: SEL_W] = SEL_W'(i + 1);
                end
            end
        end
    end

    // Per source, the youngest writer among EX and the early slots decides whether ID must wait
    always_comb begin
        src_hazard = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            for (int i = DEPTH - 2; i >= 0; i--) begin
                if (slot_valid[i] && (slot_rd[i] == id_rs[j*RA_W +: RA_W])) begin
                    src_hazard[j] = slot_load[i] && ((i + 1) < LOAD_READY);
                end
            end
            if (ex_valid && ex_regwrite && (ex_rd == id_rs[j*RA_W +: RA_W])) begin
                src_hazard[j] = ex_is_load && EX_LOAD_NOT_READY;
            end
            if (!id_valid || !id_rs_used[j] || (id_rs[j*RA_W +: RA_W] == '0)) begin
                src_hazard[j] = 1'b0;
            end
        end
        stall_comb = |src_hazard;
    end

    // Count cycles that actually stalled the pipe, sticking at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!freeze && stall_comb && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign fwd_sel   = rst ? '0 : sel_comb;
    assign ld_stall  = rst ? 1'b0 : stall_comb;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Self-checking bench for fwd_hazard_scoreboard.
// Two instances share the stimulus: the default build (DEPTH=2, LOAD_READY=1) and a
// deeper one (DEPTH=3, LOAD_READY=2, 3-bit counter) used for late-ready loads and saturation.
module tb_fwd_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        ex_valid;
    logic        ex_regwrite;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic [9:0]  ex_rs;
    logic        id_valid;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [3:0]  fwd_sel1;
    logic        ld_stall1;
    logic [31:0] stall_cnt1;
    logic [3:0]  fwd_sel2;
    logic        ld_stall2;
    logic [2:0]  stall_cnt2;

    // Reference model: a history of past EX writers, youngest at index 0
    logic        hv  [4];
    logic [4:0]  hrd [4];
    logic        hl  [4];
    logic [31:0] m_cnt1;
    logic [2:0]  m_cnt2;

    int total;
    int passed;
    int failed;
    logic [31:0] cnt_before;

    fwd_hazard_scoreboard u_dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .ex_rs(ex_rs),
        .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .fwd_sel(fwd_sel1), .ld_stall(ld_stall1), .stall_cnt(stall_cnt1)
    );

    fwd_hazard_scoreboard #(.DEPTH(3), .LOAD_READY(2), .CNT_W(3)) u_dut2 (
        .clk(clk), .rst(rst), .freeze(freeze),
        .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load),
        .ex_rd(ex_rd), .ex_rs(ex_rs),
        .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .fwd_sel(fwd_sel2), .ld_stall(ld_stall2), .stall_cnt(stall_cnt2)
    );

    // Free-running core clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Forward source: 1 + age of the youngest remembered writer of r within the first depth entries
    function automatic int model_sel(input int depth, input logic [4:0] r);
        for (int i = 0; i < depth; i++) begin
            if (hv[i] && hrd[i] == r && r != 5'd0) return i + 1;
        end
        return 0;
    endfunction

    // Position 0 is EX, position p>=1 is history entry p-1; a load at position p is late when p < lr
    function automatic logic model_stall(input int depth, input int lr);
        logic [4:0] r;
        logic       hit;
        logic       found;
        hit = 1'b0;
        for (int j = 0; j < 2; j++) begin
            r = (j == 0) ? id_rs[4:0] : id_rs[9:5];
            if (id_valid && id_rs_used[j] && r != 5'd0) begin
                found = 1'b0;
                if (ex_valid && ex_regwrite && ex_rd == r) begin
                    found = 1'b1;
                    if (ex_is_load && lr > 0) hit = 1'b1;
                end
                for (int p = 1; p < depth; p++) begin
                    if (!found && hv[p-1] && hrd[p-1] == r) begin
                        found = 1'b1;
                        if (hl[p-1] && p < lr) hit = 1'b1;
                    end
                end
            end
        end
        return rst ? 1'b0 : hit;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            hv[i]  = 1'b0;
            hrd[i] = 5'd0;
            hl[i]  = 1'b0;
        end
        m_cnt1 = 32'd0;
        m_cnt2 = 3'd0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_sel1_0"}, 32'(fwd_sel1[1:0]), 32'(model_sel(2, ex_rs[4:0])));
        checkOutput({tag, "_sel1_1"}, 32'(fwd_sel1[3:2]), 32'(model_sel(2, ex_rs[9:5])));
        checkOutput({tag, "_sel2_0"}, 32'(fwd_sel2[1:0]), 32'(model_sel(3, ex_rs[4:0])));
        checkOutput({tag, "_sel2_1"}, 32'(fwd_sel2[3:2]), 32'(model_sel(3, ex_rs[9:5])));
        checkOutput({tag, "_stall1"}, 32'(ld_stall1), 32'(model_stall(2, 1)));
        checkOutput({tag, "_stall2"}, 32'(ld_stall2), 32'(model_stall(3, 2)));
        checkOutput({tag, "_cnt1"}, stall_cnt1, m_cnt1);
        checkOutput({tag, "_cnt2"}, 32'(stall_cnt2), 32'(m_cnt2));
    endtask

    task automatic applyStimulus(input logic frz, input logic exv, input logic exrw, input logic exld,
                                 input logic [4:0] exrd, input logic [4:0] rs0, input logic [4:0] rs1,
                                 input logic idv, input logic [4:0] idrs0, input logic [4:0] idrs1,
                                 input logic [1:0] used);
        freeze      = frz;
        ex_valid    = exv;
        ex_regwrite = exrw;
        ex_is_load  = exld;
        ex_rd       = exrd;
        ex_rs       = {rs1, rs0};
        id_valid    = idv;
        id_rs       = {idrs1, idrs0};
        id_rs_used  = used;
        #1;
    endtask

    task automatic set_reset(input logic val);
        rst = val;
        if (val) clear_model();
        #1;
    endtask

    // Advance one clock; the model takes the same step the pipeline should take
    task automatic tick();
        logic s1;
        logic s2;
        s1 = model_stall(2, 1);
        s2 = model_stall(3, 2);
        @(posedge clk);
        if (!rst && !freeze) begin
            for (int i = 3; i > 0; i--) begin
                hv[i]  = hv[i-1];
                hrd[i] = hrd[i-1];
                hl[i]  = hl[i-1];
            end
            hv[0]  = ex_valid & ex_regwrite & (ex_rd != 5'd0);
            hrd[0] = ex_rd;
            hl[0]  = ex_is_load;
            if (s1 && m_cnt1 != 32'hFFFF_FFFF) m_cnt1 = m_cnt1 + 32'd1;
            if (s2 && m_cnt2 != 3'd7) m_cnt2 = m_cnt2 + 3'd1;
        end
        #1;
    endtask

    // Directed scenarios followed by a randomized run against the model
    initial begin
        total  = 0;
        passed = 0;
        failed = 0;
        rst    = 1'b1;
        clear_model();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        checkAll("rst0");
        set_reset(0);

        $display("[TB] reset mid-stream");
        applyStimulus(0, 1, 1, 1, 7, 0, 0, 1, 7, 0, 2'b01);
        checkAll("t1a");
        tick();
        applyStimulus(0, 1, 1, 0, 5, 0, 0, 0, 0, 0, 2'b00);
        tick();
        applyStimulus(0, 1, 1, 1, 7, 5, 0, 1, 7, 0, 2'b01);
        set_reset(1);
        checkAll("t1_rst");
        checkOutput("t1_sel_in_rst", 32'(fwd_sel1[1:0]), 32'd0);
        checkOutput("t1_stall_in_rst", 32'(ld_stall1), 32'd0);
        checkOutput("t1_cnt_in_rst", stall_cnt1, 32'd0);
        tick();
        set_reset(0);
        applyStimulus(0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 2'b00);
        checkAll("t1_post");
        checkOutput("t1_sel_post", 32'(fwd_sel1[1:0]), 32'd0);

        $display("[TB] forwarding age");
        applyStimulus(0, 1, 1, 0, 5, 0, 0, 0, 0, 0, 2'b00);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 2'b00);
        checkOutput("t2_n1", 32'(fwd_sel1[1:0]), 32'd1);
        checkAll("t2_n1");
        tick();
        checkOutput("t2_n2", 32'(fwd_sel1[1:0]), 32'd2);
        checkAll("t2_n2");
        tick();
        checkOutput("t2_n3", 32'(fwd_sel1[1:0]), 32'd0);
        checkAll("t2_n3");

        $display("[TB] youngest writer and x0");
        applyStimulus(0, 1, 1, 0, 5, 0, 0, 0, 0, 0, 2'b00);
        tick();
        tick();
        applyStimulus(0, 0, 0, 0, 0, 5, 5, 0, 0, 0, 2'b00);
        checkOutput("t3_src0", 32'(fwd_sel1[1:0]), 32'd1);
        checkOutput("t3_src1", 32'(fwd_sel1[3:2]), 32'd1);
        checkAll("t3_b2b");
        applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 2'b00);
        checkOutput("t3_x0", 32'(fwd_sel1[1:0]), 32'd0);
        checkOutput("t3_x0_older", 32'(fwd_sel1[3:2]), 32'd2);
        checkAll("t3_x0");

        $display("[TB] load-use");
        applyStimulus(0, 1, 1, 1, 7, 0, 0, 1, 7, 0, 2'b01);
        checkOutput("t4_stall", 32'(ld_stall1), 32'd1);
        checkOutput("t4_cnt0", stall_cnt1, 32'd0);
        checkAll("t4_a");
        applyStimulus(0, 1, 1, 1, 7, 0, 0, 1, 7, 0, 2'b00);
        checkOutput("t4_unused", 32'(ld_stall1), 32'd0);
        applyStimulus(0, 1, 1, 1, 7, 0, 0, 1, 7, 0, 2'b01);
        tick();
        checkOutput("t4_cnt1", stall_cnt1, 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 2'b01);
        checkOutput("t4_bubble", 32'(ld_stall1), 32'd0);
        checkOutput("t4_bubble_lr2", 32'(ld_stall2), 32'd1);
        checkAll("t4_b");
        tick();
        applyStimulus(0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 2'b00);
        checkOutput("t4_fwd2", 32'(fwd_sel1[1:0]), 32'd2);
        checkAll("t4_c");

        $display("[TB] shadowing");
        applyStimulus(0, 1, 1, 1, 7, 0, 0, 0, 0, 0, 2'b00);
        tick();
        applyStimulus(0, 1, 1, 0, 7, 0, 0, 1, 7, 0, 2'b01);
        checkOutput("t5_shadow1", 32'(ld_stall1), 32'd0);
        checkOutput("t5_shadow2", 32'(ld_stall2), 32'd0);
        checkAll("t5_a");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 2'b01);
        checkOutput("t5_lr2", 32'(ld_stall2), 32'd1);
        checkAll("t5_b");
        tick();

        $display("[TB] freeze and saturation");
        applyStimulus(0, 1, 1, 0, 5, 0, 0, 0, 0, 0, 2'b00);
        tick();
        applyStimulus(1, 1, 1, 1, 7, 5, 0, 1, 7, 0, 2'b01);
        cnt_before = m_cnt1;
        checkOutput("t6_stall_frz", 32'(ld_stall1), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("t6_sel_frz", 32'(fwd_sel1[1:0]), 32'd1);
            checkOutput("t6_cnt_frz", stall_cnt1, cnt_before);
            checkAll("t6_frz");
        end
        applyStimulus(0, 1, 1, 1, 7, 0, 0, 1, 7, 0, 2'b01);
        for (int k = 0; k < 9; k++) begin
            tick();
            checkAll("t6_sat");
        end
        checkOutput("t6_sat_hold", 32'(stall_cnt2), 32'd7);

        $display("[TB] random run");
        for (int n = 0; n < 400; n++) begin
            set_reset(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
            applyStimulus(($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0,
                          1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          2'($urandom));
            checkAll("rnd");
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
